// File: rtl/am2302_reader.sv
// Host-side controller for the AM2302 single-wire sensor: issues the start pulse on the
// open-drain SDA line, times the response and 40 data bits, and reports the decoded frame.
module am2302_reader #(
    parameter int unsigned CLKS_PER_US   = 50,
    parameter int unsigned START_LOW_US  = 1000,
    parameter int unsigned BIT_THRESH_US = 40,
    parameter int unsigned TIMEOUT_US    = 200,
    parameter int unsigned GAP_US        = 2000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    inout  wire         SDA,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [39:0] raw_data,
    output logic [15:0] humidity,
    output logic [15:0] temperature,
    output logic        checksum_ok
);

    localparam logic [31:0] START_LAST   = 32'(START_LOW_US * CLKS_PER_US) - 32'd1;
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_US * CLKS_PER_US) - 32'd1;
    localparam logic [31:0] GAP_LAST     = 32'(GAP_US * CLKS_PER_US) - 32'd1;
    localparam logic [31:0] THRESH_CYC   = 32'(BIT_THRESH_US * CLKS_PER_US);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START_LOW,
        ST_WAIT_RESP,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_FINISH,
        ST_ABORT,
        ST_COOLDOWN
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q, sda_prev_q;
    logic [31:0] timer_q, timer_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [39:0] shift_q, shift_d;
    logic [39:0] raw_data_q, raw_data_d;
    logic        checksum_ok_q, checksum_ok_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        sda_rise, sda_fall;
    logic        wait_expired;
    logic [7:0]  frame_sum;

    assign SDA = sda_oe_q ? 1'b0 : 1'bz;

    assign sda_rise     = sync2_q & ~sda_prev_q;
    assign sda_fall     = ~sync2_q & sda_prev_q;
    assign wait_expired = (timer_q == TIMEOUT_LAST);
    assign frame_sum    = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = ST_START_LOW;
            ST_START_LOW: if (timer_q == START_LAST) state_d = ST_WAIT_RESP;
            ST_WAIT_RESP: begin
                if (sda_fall)          state_d = ST_RESP_LOW;
                else if (wait_expired) state_d = ST_ABORT;
            end
            ST_RESP_LOW: begin
                if (sda_rise)          state_d = ST_RESP_HIGH;
                else if (wait_expired) state_d = ST_ABORT;
            end
            ST_RESP_HIGH: begin
                if (sda_fall)          state_d = ST_BIT_LOW;
                else if (wait_expired) state_d = ST_ABORT;
            end
            ST_BIT_LOW: begin
                if (sda_rise)          state_d = ST_BIT_HIGH;
                else if (wait_expired) state_d = ST_ABORT;
            end
            ST_BIT_HIGH: begin
                if (sda_fall)          state_d = (bit_cnt_q == 6'd39) ? ST_FINISH : ST_BIT_LOW;
                else if (wait_expired) state_d = ST_ABORT;
            end
            ST_FINISH:    state_d = ST_COOLDOWN;
            ST_ABORT:     state_d = ST_COOLDOWN;
            ST_COOLDOWN:  if (timer_q == GAP_LAST) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Abort signals done on entry to ABORT; a good frame signals done as FINISH loads raw_data.
    always_comb begin
        timer_d       = (state_d != state_q || state_q == ST_IDLE) ? '0 : timer_q + 32'd1;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        raw_data_d    = raw_data_q;
        checksum_ok_d = checksum_ok_q;
        done_d        = (state_q == ST_FINISH) || (state_d == ST_ABORT);
        timeout_d     = (state_d == ST_ABORT);
        sda_oe_d      = (state_d == ST_START_LOW);
        busy_d        = (state_d != ST_IDLE);

        if (state_q == ST_RESP_HIGH && sda_fall) begin
            bit_cnt_d = '0;
        end
        if (state_q == ST_BIT_HIGH && sda_fall) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            shift_d   = {shift_q[38:0], (timer_q > THRESH_CYC)};
        end
        if (state_q == ST_FINISH) begin
            raw_data_d    = shift_q;
            checksum_ok_d = (shift_q[7:0] == frame_sum);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sda_prev_q    <= 1'b0;
            timer_q       <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            raw_data_q    <= '0;
            checksum_ok_q <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            sda_oe_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            sync1_q       <= SDA;
            sync2_q       <= sync1_q;
            sda_prev_q    <= sync2_q;
            timer_q       <= timer_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            raw_data_q    <= raw_data_d;
            checksum_ok_q <= checksum_ok_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            sda_oe_q      <= sda_oe_d;
            busy_q        <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign raw_data    = raw_data_q;
    assign humidity    = raw_data_q[39:24];
    assign temperature = raw_data_q[23:8];
    assign checksum_ok = checksum_ok_q;

endmodule

// File: tb/tb_am2302_reader.sv
// Scoreboard bench for am2302_reader: directed reads against a behavioural sensor model,
// with a monitor comparing every done pulse against queued expectations.
module tb_am2302_reader;

    // Scaled timing keeps the run short: 2 clocks per microsecond.
    localparam int unsigned C         = 2;
    localparam int unsigned START_US  = 800;
    localparam int unsigned THRESH_US = 40;
    localparam int unsigned TO_US     = 200;
    localparam int unsigned GAP_US    = 500;
    localparam int START_CYC = 1600;
    localparam int TO_CYC    = 400;
    localparam int GAP_CYC   = 1000;

    typedef struct {
        logic        tout;
        logic [39:0] raw;
        logic        ok;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sens_low;
    wire         sda;
    logic        busy, done, timeout, checksum_ok;
    logic [39:0] raw_data;
    logic [15:0] humidity, temperature;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t mon_e;
    logic prev_done = 1'b0;
    int   cur_bit = -1;
    logic in_high = 1'b0;

    assign sda = sens_low ? 1'b0 : 1'bz;
    pullup (sda);

    am2302_reader #(
        .CLKS_PER_US  (C),
        .START_LOW_US (START_US),
        .BIT_THRESH_US(THRESH_US),
        .TIMEOUT_US   (TO_US),
        .GAP_US       (GAP_US)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .start      (start),
        .SDA        (sda),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .raw_data   (raw_data),
        .humidity   (humidity),
        .temperature(temperature),
        .checksum_ok(checksum_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Returns on the first negedge with SDA released again (first WAIT_RESP cycle).
    task automatic host_start();
        int low_cnt;
        pulse_start();
        check("accept_busy", busy, 1);
        check("accept_sda_low", sda, 0);
        low_cnt = 1;
        for (int i = 0; i < START_CYC + 50; i++) begin
            @(negedge clk);
            if (sda !== 1'b0) break;
            low_cnt++;
        end
        check("start_low_width", low_cnt, START_CYC);
    endtask

    task automatic sensor_frame(input logic [39:0] f);
        hold(30 * C);
        sens_low = 1'b1; hold(80 * C);
        sens_low = 1'b0; hold(80 * C);
        for (int i = 39; i >= 0; i--) begin
            sens_low = 1'b1; hold(50 * C);
            sens_low = 1'b0;
            cur_bit  = 39 - i;
            in_high  = 1'b1;
            hold(f[i] ? 70 * C : 26 * C);
            in_high  = 1'b0;
        end
        sens_low = 1'b1; hold(50 * C);
        sens_low = 1'b0;
        cur_bit  = -1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < GAP_CYC + 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic cooldown_probe();
        int lows, n;
        hold(20);
        check("busy_in_cooldown", busy, 1);
        pulse_start();
        lows = 0;
        n    = 0;
        while (busy === 1'b1 && n < GAP_CYC + 2000) begin
            @(negedge clk);
            if (sda === 1'b0) lows++;
            n++;
        end
        check("cooldown_start_no_drive", lows, 0);
        check("cooldown_ends", busy, 0);
        hold(10);
        check("start_not_queued_busy", busy, 0);
        check("start_not_queued_sda", sda, 1);
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (rst !== 1'b1 && done === 1'b1) begin
            check("done_single_cycle", prev_done, 0);
            if (q.size() == 0) begin
                check("done_expected", done, 0);
            end else begin
                mon_e = q.pop_front();
                check("timeout", timeout, mon_e.tout);
                check("raw_data", raw_data, mon_e.raw);
                check("humidity", humidity, mon_e.raw[39:24]);
                check("temperature", temperature, mon_e.raw[23:8]);
                check("checksum_ok", checksum_ok, mon_e.ok);
            end
        end
        prev_done = done;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; sens_low = 1'b0;
        hold(5);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_raw", raw_data, 0);
        check("rst_hum", humidity, 0);
        check("rst_temp", temperature, 0);
        check("rst_ok", checksum_ok, 0);
        check("rst_sda", sda, 1);
        rst = 1'b0;
        hold(5);

        q.push_back(exp_t'{tout: 1'b0, raw: 40'h1234567814, ok: 1'b1});
        host_start();
        sensor_frame(40'h1234567814);
        cooldown_probe();

        q.push_back(exp_t'{tout: 1'b0, raw: 40'h9ABCDEF024, ok: 1'b1});
        host_start();
        sensor_frame(40'h9ABCDEF024);
        wait_idle("read2_idle");

        // No sensor: only the pull-up answers; previous frame must be retained.
        q.push_back(exp_t'{tout: 1'b1, raw: 40'h9ABCDEF024, ok: 1'b1});
        host_start();
        n = 0;
        while (done !== 1'b1 && n < TO_CYC + 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", n, TO_CYC);
        wait_idle("nosensor_idle");

        q.push_back(exp_t'{tout: 1'b0, raw: 40'h1234567815, ok: 1'b0});
        host_start();
        sensor_frame(40'h1234567815);
        wait_idle("corrupt_idle");

        host_start();
        fork
            sensor_frame(40'h1234567814);
            begin
                int w;
                w = 0;
                while (!(cur_bit == 19 && in_high) && w < 20000) begin
                    @(negedge clk);
                    w++;
                end
                hold(10);
                check("busy_before_rst", busy, 1);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("midrst_busy", busy, 0);
                check("midrst_sda", sda, 1);
                check("midrst_done", done, 0);
                check("midrst_raw", raw_data, 0);
                check("midrst_ok", checksum_ok, 0);
            end
        join
        hold(200);

        q.push_back(exp_t'{tout: 1'b0, raw: 40'hA55A0F0F1D, ok: 1'b1});
        host_start();
        sensor_frame(40'hA55A0F0F1D);
        wait_idle("final_idle");

        check("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/am2302_reader.md
# am2302_reader

Synthesizable host-side controller for the AM2302 single-wire humidity/temperature sensor bus. On a `start` request it drives the host start pulse on `SDA`, then releases the line. It times the sensor's response and 40 data bits, and presents humidity, temperature and checksum status to the system. It sits between the system logic and the open-drain `SDA` pad, which has an external pull-up.

## Interface
Parameters:
- `CLKS_PER_US`, 50: `CLK` cycles per microsecond (50 MHz default).
- `START_LOW_US`, 1000: host start-pulse low time. Must be at least 800.
- `BIT_THRESH_US`, 40: a data-bit high time strictly greater than this decodes as 1.
- `TIMEOUT_US`, 200: maximum wait in any single wait state.
- `GAP_US`, 2000: cooldown after a transaction ends, during which `start` is ignored.

Ports:
- `CLK`, in, 1: the single clock.
- `RST`, in, 1: reset. It is synchronous and active-high.
- `start`, in, 1: single-cycle request to begin a read. Ignored while `busy`.
- `SDA`, inout, 1: bus line. Driven `0` when the output enable is high, otherwise high-Z. The block never drives `1`.
- `busy`, out, 1: high from the cycle after `start` is accepted until cooldown ends.
- `done`, out, 1: one-cycle pulse at the end of each transaction.
- `timeout`, out, 1: valid with `done`. High when the transaction aborted on a timeout.
- `raw_data`, out, 40: last successfully received frame, MSB first.
- `humidity`, out, 16: equals `raw_data[39:24]`.
- `temperature`, out, 16: equals `raw_data[23:8]`.
- `checksum_ok`, out, 1: `raw_data[7:0]` equals the modulo-256 sum of `raw_data[39:32]`, `[31:24]`, `[23:16]` and `[15:8]`.

## Operation
Input path:
- `SDA` passes through a 2-flop synchronizer followed by one edge register.
- Rise and fall detections are therefore 3 cycles after the pin edge.

Timer:
- A single 32-bit cycle counter is cleared on every state entry.
- All limits are computed as `X_US*CLKS_PER_US`.

States:
- **IDLE**: `SDA` is released. On `start`, go to **START_LOW**.
- **START_LOW**: drive `SDA` low for exactly `START_LOW_US*CLKS_PER_US` cycles, then release and go to **WAIT_RESP**.
- **WAIT_RESP**: wait for a synchronized fall, which is the sensor's 80 µs response low. Then go to **RESP_LOW**.
- **RESP_LOW**: on rise, go to **RESP_HIGH**.
- **RESP_HIGH**: on fall, clear the bit counter and go to **BIT_LOW**.
- **BIT_LOW**: this is the ~50 µs low that precedes each bit. On rise, go to **BIT_HIGH**.
- **BIT_HIGH**: on fall, shift in the bit: `1` if the timer is greater than `BIT_THRESH_US*CLKS_PER_US`, else `0`. Then:
  - if this was bit 40, go to **FINISH**;
  - otherwise go to **BIT_LOW**.
- **FINISH**: load `raw_data` from the shift register, compute `checksum_ok`, pulse `done` with `timeout=0`, then go to **COOLDOWN**.
- **COOLDOWN**: wait `GAP_US*CLKS_PER_US` cycles, then go to **IDLE**.
  - `busy` falls on the transition to **IDLE**.

Timeouts and errors:
- In any wait state from **WAIT_RESP** through **BIT_HIGH**, if the timer reaches `TIMEOUT_US*CLKS_PER_US`, go to **ABORT**.
- **ABORT**: pulse `done` with `timeout=1`, then go to **COOLDOWN**.
  - On abort, `raw_data` and `checksum_ok` keep their previous values.
- A bad checksum is not an error. The frame is still loaded into `raw_data`, with `checksum_ok=0`.

## Timing
Reset:
- When `RST` is high at a clock edge, every register is cleared next cycle: `SDA` released, `busy=0`, `done=0`, `timeout=0`, `raw_data=0`, `checksum_ok=0`, state **IDLE**.
- `checksum_ok` is 0 after reset (registered, not combinational).
- `RST` has priority over `start` in the same cycle.
- `RST` mid-transaction releases `SDA` on the next cycle.

Start:
- `start` is accepted in **IDLE** only.
- `SDA` goes low and `busy` goes high on the cycle after acceptance.
- The `SDA` low width is exactly `START_LOW_US*CLKS_PER_US` cycles: 50,000 cycles at the defaults.

Result timing:
- `done`, `raw_data` and `checksum_ok` update on the same cycle.
- That cycle is the one after the 40th bit's synchronized fall, i.e. 4 cycles after the pin edge.

Bit decode:
- The measured high time includes synchronizer skew, which is equal on both edges, so no correction is needed.
- At the defaults, a 26 µs high decodes as 0 and a 70 µs high decodes as 1.

Other rules:
- `start` pulses during `busy` are dropped and not queued.
- `done` is never high for more than one cycle.

## Test plan
- Reset: hold `RST` for 5 cycles -> all outputs 0, `SDA` high-Z (reads 1 via pull-up), `busy=0`.
- First read against the sensor model: pulse `start` -> `SDA` low for exactly 50,000 cycles. Then `done` with `raw_data=40'h1234567814`, `humidity=16'h1234`, `temperature=16'h5678`, `checksum_ok=1`, `timeout=0`.
- Second read after cooldown: `raw_data=40'h9ABCDEF024`, `humidity=16'h9ABC`, `temperature=16'hDEF0`, `checksum_ok=1`. A `start` issued during the prior cooldown is ignored.
- No sensor (pull-up only): `start` -> `done` with `timeout=1` exactly 10,000 cycles after entering **WAIT_RESP**. `raw_data` is unchanged.
- Corrupted frame: force bit 0 of the checksum byte to flip -> `done`, `timeout=0`, `checksum_ok=0`, `raw_data[7:0]=8'h15`.
- `RST` asserted during **BIT_HIGH** of bit 20 -> `SDA` released and `busy=0` next cycle. After the sensor's idle gap, a new `start` reads a valid frame.
